// File: rtl/s5_pll_lock_sequencer.sv
// Reset/lock qualification sequencer for one PLL instance, clocked by a free-running system clock.
// Pulses pll_rst, filters a synchronised lock, and retries on timeout or lock loss.
//
// state      | meaning
// RESET      | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK  | waiting for synced lock, bounded by LOCK_TIMEOUT
// FILTER     | counting LOCK_STABLE unbroken locked cycles
// LOCKED     | pll_ready high; any captured drop is a loss
// FAIL       | retries exhausted; held until restart or rst_n
module s5_pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             pll_ready,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] RETRY_LIM   = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   retry_inc;
  logic               lk_meta_q, lk_s_q;
  logic               pll_rst_q, pll_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      timer_q   <= '0;
      loss_q    <= '0;
      retry_q   <= '0;
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    loss_d    = loss_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;
    // restart overrides every transition, including a coincident lock loss
    if (restart) begin
      state_d = ST_RESET;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_s_q) begin
            state_d = ST_FILTER;
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_RESET;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_FILTER: begin
          if (!lk_s_q) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_LOCKED;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!lk_s_q) begin
            loss_d  = (loss_q == CNT_MAX) ? loss_q : loss_q + 1'b1;
            state_d = ST_RESET;
            timer_d = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          timer_d = '0;
        end
      endcase
    end
    pll_rst_d = (state_d == ST_RESET);
    ready_d   = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAIL);
  end

  assign pll_rst     = pll_rst_q;
  assign pll_ready   = ready_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_s5_pll_lock_sequencer.sv
// Scoreboard bench: stimulus queues expected state transitions, a monitor pops one per observed transition.
module tb_s5_pll_lock_sequencer;

  localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_FILT = 3'd2, S_LOCK = 3'd3, S_FAIL = 3'd4;

  logic       clk, rst_n, restart, pll_locked;
  logic       pll_rst, pll_ready, fail;
  logic [2:0] state;
  logic [1:0] loss_count, retry_count;

  typedef struct {
    logic [2:0] st;
    int         dwell;
    logic       rst;
    logic       rdy;
    logic       fl;
    logic [1:0] retry;
    logic [1:0] loss;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  s5_pll_lock_sequencer #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(32), .LOCK_STABLE(64), .MAX_RETRY(3), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .pll_ready(pll_ready), .fail(fail), .state(state),
    .loss_count(loss_count), .retry_count(retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input int dwell, input logic r, input logic rdy,
                      input logic f, input int retry, input int loss);
    exp_t e;
    e.st = st; e.dwell = dwell; e.rst = r; e.rdy = rdy; e.fl = f;
    e.retry = 2'(retry); e.loss = 2'(loss);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [2:0] prev;
    int         cnt;
    exp_t       e;
    prev = S_RST;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = S_RST;
        cnt  = 0;
      end else if (state != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition actual state=%0d after %0d cycles required none", state, cnt);
        end else begin
          e = q.pop_front();
          if (state !== e.st || pll_rst !== e.rst || pll_ready !== e.rdy || fail !== e.fl ||
              retry_count !== e.retry || loss_count !== e.loss || (e.dwell >= 0 && cnt != e.dwell)) begin
            errors++;
            $display("FAIL transition actual st=%0d dwell=%0d rst=%b rdy=%b fail=%b retry=%0d loss=%0d required st=%0d dwell=%0d rst=%b rdy=%b fail=%b retry=%0d loss=%0d",
                     state, cnt, pll_rst, pll_ready, fail, retry_count, loss_count,
                     e.st, e.dwell, e.rst, e.rdy, e.fl, e.retry, e.loss);
          end
        end
        prev = state;
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lp, ln;
    fork
      monitor();
    join_none
    rst_n = 1'b1; restart = 1'b0; pll_locked = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_values", {20'd0, state, pll_rst, pll_ready, fail, retry_count, loss_count},
        {20'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});

    // nominal: lock raised 40 cycles after release
    push(S_WAIT, 16, 0, 0, 0, 0, 0);
    push(S_FILT, 27, 0, 0, 0, 0, 0);
    push(S_LOCK, 64, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    tick(8);
    chk("pll_rst_in_window", {31'd0, pll_rst}, 32'd1);
    tick(32);
    pll_locked = 1'b1;
    tick(70);

    // loss of lock, then a filter bounce on relock
    push(S_RST, -1, 1, 0, 0, 0, 1);
    pll_locked = 1'b0;
    tick(2);
    chk("ready_before_loss_seen", {31'd0, pll_ready}, 32'd1);
    tick(1);
    chk("loss_latency", {30'd0, pll_ready, pll_rst}, 32'b01);
    push(S_WAIT, 16, 0, 0, 0, 0, 1);
    push(S_FILT, 7,  0, 0, 0, 0, 1);
    push(S_WAIT, 30, 0, 0, 0, 0, 1);
    push(S_FILT, 1,  0, 0, 0, 0, 1);
    push(S_LOCK, 64, 0, 1, 0, 0, 1);
    tick(20);
    pll_locked = 1'b1;
    tick(30);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(40);
    chk("no_ready_mid_refilter", {31'd0, pll_ready}, 32'd0);
    tick(40);

    // restart coincident with lock loss: loss not counted
    push(S_RST, -1, 1, 0, 0, 0, 1);
    pll_locked = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;

    // timeouts with lock held low
    push(S_WAIT, 16, 0, 0, 0, 0, 1);
    push(S_RST,  32, 1, 0, 0, 1, 1);
    push(S_WAIT, 16, 0, 0, 0, 1, 1);
    push(S_RST,  32, 1, 0, 0, 2, 1);
    push(S_WAIT, 16, 0, 0, 0, 2, 1);
    push(S_FAIL, 32, 0, 0, 1, 3, 1);
    tick(160);
    chk("fail_hold", {25'd0, state, pll_rst, fail, retry_count}, {25'd0, 3'd4, 1'b0, 1'b1, 2'd3});

    // restart from FAIL, then restart again inside RESET
    push(S_RST,  -1, 1, 0, 0, 0, 1);
    push(S_WAIT, 21, 0, 0, 0, 0, 1);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("restart_clears", {28'd0, fail, pll_rst, retry_count}, {28'd0, 1'b0, 1'b1, 2'd0});
    tick(4);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(20);

    // four more losses saturate the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      lp = (1 + i > 3) ? 3 : 1 + i;
      ln = (2 + i > 3) ? 3 : 2 + i;
      push(S_FILT, -1, 0, 0, 0, 0, lp);
      push(S_LOCK, 64, 0, 1, 0, 0, lp);
      push(S_RST,  -1, 1, 0, 0, 0, ln);
      push(S_WAIT, 16, 0, 0, 0, 0, ln);
      pll_locked = 1'b1;
      tick(75);
      pll_locked = 1'b0;
      tick(23);
    end
    chk("loss_saturated", {30'd0, loss_count}, 32'd3);

    // async reset mid-FILTER
    push(S_FILT, -1, 0, 0, 0, 0, 3);
    pll_locked = 1'b1;
    tick(20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {20'd0, state, pll_rst, pll_ready, fail, retry_count, loss_count},
        {20'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0});
    pll_locked = 1'b0;
    push(S_WAIT, 16, 0, 0, 0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
